// File: rtl/cpu_out_capture_if.sv
// Consumer-side handshake bundle for cpu_out_capture: head value, valid/ready and,
// when CPUOUT_TIMESTAMP_EN is defined, the head entry's capture timestamp.
interface cpu_out_capture_if
`ifdef CPUOUT_TIMESTAMP_EN
  #(parameter int TS_W = 16)
`endif
  ;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef CPUOUT_TIMESTAMP_EN
  logic [TS_W-1:0] out_ts;

  modport master (output out_data, output out_valid, output out_ts, input out_ready);
  modport slave  (input out_data, input out_valid, input out_ts, output out_ready);
`else
  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/cpu_out_capture.sv
// Captures every change on the CPU output bus into a FIFO and hands the values to a
// slower consumer over valid/ready; optional capture timestamps via CPUOUT_TIMESTAMP_EN.
module cpu_out_capture #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
`ifdef CPUOUT_TIMESTAMP_EN
  ,
  parameter int TS_W   = 16
`endif
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [31:0]                CPUOut,
  cpu_out_capture_if.master          sink,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          primed;
  logic [31:0]   last_val;

  logic push_req;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_req = !primed || (CPUOut != last_val);
    pop      = (count != '0) && sink.out_ready;
    full     = (count == CW'(DEPTH));
    accept   = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  assign sink.out_valid = (count != '0);
  assign sink.out_data  = mem[rptr];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      primed   <= 1'b0;
      last_val <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_req) begin
        primed   <= 1'b1;
        last_val <= CPUOut;
      end
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset && accept) mem[wptr] <= CPUOut;
  end

`ifdef CPUOUT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (Reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  // Entries record the counter value as it stands at their push edge.
  always_ff @(posedge CLK) begin
    if (!Reset && accept) ts_mem[wptr] <= ts_cnt;
  end

  assign sink.out_ts = ts_mem[rptr];
`endif

endmodule

// File: tb/tb_cpu_out_capture.sv
// Directed, table-driven bench for cpu_out_capture (DEPTH=8, DROP_W=8); the timestamp
// sequence runs only when CPUOUT_TIMESTAMP_EN is defined.
module tb_cpu_out_capture;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] CPUOut;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  cpu_out_capture_if sink_if ();

  cpu_out_capture #(.DEPTH(8), .DROP_W(8)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .CPUOut   (CPUOut),
    .sink     (sink_if),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [31:0] cpu;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_count;
    logic        exp_ovf;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[$];

  function void add_vec(input logic rst, input logic [31:0] cpu, input logic rdy,
                        input logic ev, input logic [31:0] ed, input logic [3:0] ec,
                        input logic eo, input logic [7:0] edr);
    vec_t v;
    v.rst = rst; v.cpu = cpu; v.rdy = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec;
    v.exp_ovf = eo; v.exp_drop = edr;
    vecs.push_back(v);
  endfunction

  task automatic check_field(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] cpu, input logic rdy);
    @(negedge CLK);
    Reset             = rst;
    CPUOut            = cpu;
    sink_if.out_ready = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check_field("out_valid", idx, {31'd0, sink_if.out_valid}, {31'd0, v.exp_valid});
    if (v.exp_valid) check_field("out_data", idx, sink_if.out_data, v.exp_data);
    check_field("count", idx, {28'd0, count}, {28'd0, v.exp_count});
    check_field("overflow", idx, {31'd0, overflow}, {31'd0, v.exp_ovf});
    check_field("drop_cnt", idx, {24'd0, drop_cnt}, {24'd0, v.exp_drop});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset             = 1'b1;
    CPUOut            = '0;
    sink_if.out_ready = 1'b0;

    // Held value: pushed once only.
    add_vec(1, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add_vec(0, 32'h1F, 0, 1, 32'h1F, 1, 0, 0);

    // Repeats suppressed, then drain.
    add_vec(1, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    add_vec(0, 32'h1, 0, 1, 32'h1, 1, 0, 0);
    add_vec(0, 32'h1, 0, 1, 32'h1, 1, 0, 0);
    add_vec(0, 32'h2, 0, 1, 32'h1, 2, 0, 0);
    add_vec(0, 32'h2, 0, 1, 32'h1, 2, 0, 0);
    add_vec(0, 32'h3, 0, 1, 32'h1, 3, 0, 0);
    add_vec(0, 32'h3, 1, 1, 32'h2, 2, 0, 0);
    add_vec(0, 32'h3, 1, 1, 32'h3, 1, 0, 0);
    add_vec(0, 32'h3, 1, 0, 32'h0, 0, 0, 0);

    // Overflow: ten distinct values into eight slots.
    add_vec(1, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      add_vec(0, 32'h10 + k, 0, 1, 32'h10, (k < 8) ? 4'(k + 1) : 4'd8,
              k >= 8, (k >= 8) ? 8'(k - 7) : 8'd0);
    for (int j = 0; j < 8; j++)
      add_vec(0, 32'h19, 1, j < 7, 32'h11 + j, 4'(7 - j), 1, 2);

    // Full with simultaneous push and pop.
    add_vec(1, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add_vec(0, 32'h20 + k, 0, 1, 32'h20, 4'(k + 1), 0, 0);
    for (int j = 0; j < 4; j++) add_vec(0, 32'h28 + j, 1, 1, 32'h21 + j, 8, 0, 0);
    for (int j = 0; j < 8; j++) add_vec(0, 32'h2B, 1, j < 7, 32'h25 + j, 4'(7 - j), 0, 0);

    // Reset mid-stream with the same value on both sides, then replace-at-count-1.
    add_vec(1, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add_vec(0, 32'h30 + k, 0, 1, 32'h30, 4'(k + 1), 0, 0);
    add_vec(0, 32'hAA, 0, 1, 32'h30, 6, 0, 0);
    add_vec(1, 32'hAA, 0, 0, 32'h0, 0, 0, 0);
    add_vec(0, 32'hAA, 0, 1, 32'hAA, 1, 0, 0);
    add_vec(0, 32'hAA, 0, 1, 32'hAA, 1, 0, 0);
    add_vec(0, 32'hBB, 1, 1, 32'hBB, 1, 0, 0);
    add_vec(0, 32'hBB, 1, 0, 32'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].cpu, vecs[i].rdy);
      checkOutput(i, vecs[i]);
    end

    // Drop counter saturation: 260 drops against an 8-bit counter.
    applyStimulus(1, 32'h0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 32'h100 + k, 0);
    for (int k = 0; k < 260; k++) applyStimulus(0, 32'h200 + k, 0);
    check_field("sat_drop_cnt", 1000, {24'd0, drop_cnt}, 32'hFF);
    check_field("sat_overflow", 1000, {31'd0, overflow}, 32'h1);
    check_field("sat_count", 1000, {28'd0, count}, 32'd8);
    check_field("sat_head", 1000, sink_if.out_data, 32'h100);
    applyStimulus(1, 32'h0, 0);
    check_field("clr_drop_cnt", 1001, {24'd0, drop_cnt}, 32'h0);
    check_field("clr_overflow", 1001, {31'd0, overflow}, 32'h0);

`ifdef CPUOUT_TIMESTAMP_EN
    // Pushes at cycles 0, 3 and 7 after reset.
    applyStimulus(0, 32'h1, 0);
    check_field("ts_first", 2000, 32'(sink_if.out_ts), 32'd0);
    applyStimulus(0, 32'h1, 0);
    applyStimulus(0, 32'h1, 0);
    applyStimulus(0, 32'h2, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 32'h2, 0);
    applyStimulus(0, 32'h3, 0);
    check_field("ts_count", 2001, {28'd0, count}, 32'd3);
    check_field("ts_head0", 2002, 32'(sink_if.out_ts), 32'd0);
    applyStimulus(0, 32'h3, 1);
    check_field("ts_head1", 2003, 32'(sink_if.out_ts), 32'd3);
    check_field("ts_data1", 2003, sink_if.out_data, 32'h2);
    applyStimulus(0, 32'h3, 1);
    check_field("ts_head2", 2004, 32'(sink_if.out_ts), 32'd7);
    check_field("ts_data2", 2004, sink_if.out_data, 32'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_out_capture.md
Name: cpu_out_capture

Overview:
- Downstream of the risc_v core; samples the CPU's 32-bit output bus `CPUOut` on every clock.
- Records each new value into a FIFO, so that no transient write made by the program is lost.
- Hands the recorded values to a slower consumer (display/log port) over a valid/ready handshake.
- Flags and counts values lost to FIFO overflow.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- DROP_W, 8, width of the saturating drop counter.
- TS_W, 16, timestamp width; used only when CPUOUT_TIMESTAMP_EN is defined.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- CPUOut  input  32  CPU output bus, sampled every rising edge.
- out_data  output  32  FIFO head value.
- out_valid  output  1  high when FIFO is non-empty.
- out_ready  input  1  consumer accepts head when out_valid && out_ready at an edge.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set on first dropped value.
- drop_cnt  output  DROP_W  number of dropped values; saturates at all-ones.

Behaviour:
- Reset (Reset=1 at an edge) clears all of the following:
  - out_valid=0, count=0, overflow=0, drop_cnt=0.
  - Read and write pointers = 0, primed=0, last_val=0.
  - out_data holds whatever is in the head slot; don't care while out_valid=0.
- Reset overrides any concurrent push or pop in the same cycle.
- Change detect (push request):
  - If primed=0: push CPUOut unconditionally and set primed=1. This is the first edge after Reset deasserts.
  - If primed=1: push when CPUOut != last_val.
  - last_val <= CPUOut on every push request, whether the value is accepted or dropped.
- Pop occurs when out_valid && out_ready. The read pointer advances, wrapping modulo DEPTH.
- Latency: a value pushed at edge N appears on out_data/out_valid after edge N. There is no combinational fall-through from CPUOut.
- Full / simultaneous cases:
  - push && !pop && count==DEPTH: value dropped; overflow<=1; drop_cnt increments, saturating.
  - push && pop when full: both succeed; count stays DEPTH; no drop.
  - push && pop when count==1: head is replaced by the new value after the edge; count stays 1.
  - pop when empty is impossible, because out_valid=0.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is registered: +1 on push only, −1 on pop only, unchanged on both or neither.
- overflow and drop_cnt clear only on Reset.
- Reset mid-operation: all queued entries are discarded. The next post-reset sample is captured as a fresh first value, even if it equals the pre-reset value.

Optional Feature:
- Macro: CPUOUT_TIMESTAMP_EN.
- Defined:
  - Adds a TS_W-bit free-running cycle counter, cleared by Reset and incremented every non-reset cycle with wrap-around.
  - Each FIFO entry also stores the counter value at its push edge.
  - Adds output port out_ts [TS_W-1:0], aligned with out_data. The first value after reset carries ts=0.
- Undefined:
  - No counter, no out_ts port, no timestamp storage.
  - All other behaviour is identical.

Test Plan:
- Reset=1 for 1 edge, then CPUOut=32'h0000001F held, out_ready=0:
  - after first edge: out_valid=1, out_data=1F, count=1;
  - later edges push nothing, count stays 1.
- Steady-state count check: CPUOut sequence 1,1,2,2,3 with out_ready=0 -> count=3; drain with out_ready=1 -> out_data 1,2,3 on successive cycles, then out_valid=0.
- Overflow: DEPTH=8, out_ready=0, CPUOut changes to 10 distinct values on consecutive edges:
  - count=8, overflow=1, drop_cnt=2;
  - drain yields the first 8 values in order.
- Full with simultaneous push+pop: fill to 8, then out_ready=1 while CPUOut keeps changing:
  - count stays 8, drop_cnt unchanged, order preserved.
- Reset mid-stream: 5 entries queued, assert Reset with CPUOut=32'hAA both before and after:
  - count=0, overflow=0 on reset;
  - first post-reset edge captures AA, count=1.
- With CPUOUT_TIMESTAMP_EN: values pushed at cycles 0, 3, 7 after reset -> out_ts reads 0, 3, 7 in order.
